// File: rtl/adder_serial.sv
// Bit-serial adder/subtractor: processes SLICE bits per clock, LSB slice first,
// and publishes s/co/ovf atomically once the last slice has been added.
module adder_serial_slice #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
endmodule

module adder_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                  state;
  logic [N-1:0][SLICE-1:0]     a_r, b_r, sum_r, sum_nxt;
  logic                        carry, sub_r;
  logic [CW-1:0]               cnt;
  logic [SLICE-1:0]            sl_sum;
  logic                        sl_co;
  logic                        msb_ci;

  // b is stored pre-inverted for subtract so the datapath is always an add
  adder_serial_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_r[cnt]),
    .b  (b_r[cnt]),
    .ci (carry),
    .s  (sl_sum),
    .co (sl_co)
  );

  always_comb begin
    sum_nxt      = sum_r;
    sum_nxt[cnt] = sl_sum;
  end

  // carry into the MSB recovered from the MSB sum bit (valid on the last slice)
  assign msb_ci = a_r[N-1][SLICE-1] ^ b_r[N-1][SLICE-1] ^ sl_sum[SLICE-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      carry <= 1'b0;
      sub_r <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r   <= a;
          b_r   <= b ^ {WIDTH{sub}};
          carry <= ci ^ sub;
          sub_r <= sub;
          sum_r <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          sum_r <= sum_nxt;
          carry <= sl_co;
          if (cnt == LAST) begin
            s     <= sum_nxt;
            co    <= sl_co ^ sub_r;
            ovf   <= msb_ci ^ sl_co;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_adder_serial.sv
// Bench for adder_serial: arithmetic reference model with per-cycle checker on
// an 8/2 instance, plus directed literal checks and an exhaustive 2/2 instance.
module tb_adder_serial;
  localparam int N8 = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sub, ci;
  logic [7:0] a, b;
  logic       busy, done, co, ovf;
  logic [7:0] s;

  logic       start2, sub2, ci2;
  logic [1:0] a2, b2;
  logic       busy2, done2, co2, ovf2;
  logic [1:0] s2;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int phase;
  logic [9:0] held, pend;   // {co, ovf, s}

  always #5 clk = ~clk;

  adder_serial #(.WIDTH(8), .SLICE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
  );

  adder_serial #(.WIDTH(2), .SLICE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2), .ci(ci2),
    .busy(busy2), .done(done2), .s(s2), .co(co2), .ovf(ovf2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: {co, ovf, s}
  function automatic logic [9:0] ref_op(input logic [7:0] fa, input logic [7:0] fb,
                                        input logic fci, input logic fsub);
    int ua, ub, sa, sb, r, sr;
    logic [7:0] rs;
    logic rco, rovf;
    ua = fa; ub = fb;
    sa = (fa >= 8'h80) ? ua - 256 : ua;
    sb = (fb >= 8'h80) ? ub - 256 : ub;
    if (!fsub) begin
      r   = ua + ub + fci;
      sr  = sa + sb + fci;
      rco = (r > 255);
    end else begin
      r   = ua - ub - fci;
      sr  = sa - sb - fci;
      rco = (ua < ub + fci);
    end
    rs   = r[7:0];
    rovf = (sr > 127) || (sr < -128);
    return {rco, rovf, rs};
  endfunction

  // Protocol model: phase 0 idle, 1..N running, N+1 done cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      held  = '0;
    end else if (phase == 0) begin
      if (start) begin
        pend  = ref_op(a, b, ci, sub);
        phase = 1;
      end
    end else if (phase == N8 + 1) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == N8 + 1) held = pend;
    end
  end

  always @(negedge clk) begin
    logic [11:0] exp_v;
    if (!rst_n) begin
      chk("reset_outs", {busy, done, co, ovf, s}, 32'h0);
    end else begin
      exp_v = {(phase >= 1 && phase <= N8), (phase == N8 + 1), held};
      chk("cycle", {busy, done, co, ovf, s}, exp_v);
      if (done) done_cnt++;
    end
  end

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tci,
                        input logic tsub, input logic [7:0] es, input logic eco,
                        input logic eovf, input string nm);
    int c;
    @(negedge clk);
    a = ta; b = tb_v; ci = tci; sub = tsub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!done && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_latency"}, c, N8);
    chk({nm, "_s"}, s, es);
    chk({nm, "_co"}, co, eco);
    chk({nm, "_ovf"}, ovf, eovf);
    @(negedge clk);
  endtask

  initial begin
    int dc;
    int sa, sb, sr;
    rst_n = 1'b0;
    start = 0; sub = 0; ci = 0; a = 0; b = 0;
    start2 = 0; sub2 = 0; ci2 = 0; a2 = 0; b2 = 0;
    #1;
    chk("reset_literal", {busy, done, co, ovf, s}, 32'h0);
    #11 rst_n = 1'b1;

    run_op(8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, "add_ovf");
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, "add_wrap");
    run_op(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, "sub_borrow");
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, "sub_ovf");
    run_op(8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, "sub_bin");

    // start held high, operands changing every cycle
    dc = done_cnt;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      start = 1'b1;
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_start_dones", done_cnt - dc, 4);

    // reset during the second RUN cycle
    @(negedge clk);
    a = 8'h77; b = 8'h11; ci = 0; sub = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {busy, done, co, ovf, s}, 32'h0);
    dc = done_cnt;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "post_reset");

    // WIDTH=2, SLICE=2 exhaustive add
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a2 = 2'(ia); b2 = 2'(ib); ci2 = 1'(ic); start2 = 1'b1;
          @(negedge clk);
          start2 = 1'b0;
          chk("w2_run", {busy2, done2}, 2'b10);
          @(negedge clk);
          sa = (ia >= 2) ? ia - 4 : ia;
          sb = (ib >= 2) ? ib - 4 : ib;
          sr = sa + sb + ic;
          chk("w2_done", {busy2, done2, co2, s2}, {2'b01, 3'(ia + ib + ic)});
          chk("w2_ovf", ovf2, (sr > 1 || sr < -2));
        end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
